// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: owns the fetch PC, issues one instruction-bus
// request at a time, and holds the returned word in a single-entry buffer
// until decode takes it. A redirect squashes the buffer. If a redirect
// arrives while a request is in flight, that response is drained and dropped.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  input  logic        stallM,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        stallI,
  output logic [63:0] pc
);

  localparam logic [63:0] STEP = 64'(PC_STEP);

  // S_REQ   : buffer empty, live request outstanding at pc
  // S_WAIT  : buffer full, no request on the bus
  // S_DRAIN : request at pc is stale; wait for its response, then go to target
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nx;
  logic [63:0] pc_nx, target, target_nx, if_pc_nx;
  logic [31:0] if_instr_nx;
  logic        if_valid_nx;
  logic        accept;

  assign accept     = if_valid && !stall && !stallM;
  // The address does not need a separate hold register. pc is left unchanged
  // while a request is outstanding, including in DRAIN, so it is the frozen
  // request address.
  assign ireq_valid = reset && (state != S_WAIT);
  assign ireq_addr  = pc;
  assign stallI     = !if_valid;

  // Register state, PC, drain target and the output buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      target   <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      target   <= target_nx;
      if_valid <= if_valid_nx;
      if_pc    <= if_pc_nx;
      if_instr <= if_instr_nx;
    end
  end

  // Compute the next state and the register updates for each bus and redirect event.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    target_nx   = target;
    if_valid_nx = if_valid;
    if_pc_nx    = if_pc;
    if_instr_nx = if_instr;
    unique case (state)
      S_REQ: begin
        if (iresp_data_ok && !redirect) begin
          if_valid_nx = 1'b1;
          if_pc_nx    = pc;
          if_instr_nx = iresp_data;
          pc_nx       = pc + STEP;
          state_nx    = S_WAIT;
        end else if (iresp_data_ok) begin
          // The response and the redirect land together. Drop the word and refetch at once.
          pc_nx = redirect_pc;
        end else if (redirect) begin
          // The bus still owes a response at the old address. Park the target.
          target_nx = redirect_pc;
          state_nx  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (iresp_data_ok) begin
          pc_nx    = redirect ? redirect_pc : target;
          state_nx = S_REQ;
        end else if (redirect) begin
          target_nx = redirect_pc;
        end
      end
      S_WAIT: begin
        // A redirect wins over any stall. A response cannot arrive here, so it is ignored.
        if (redirect) begin
          if_valid_nx = 1'b0;
          pc_nx       = redirect_pc;
          state_nx    = S_REQ;
        end else if (accept) begin
          if_valid_nx = 1'b0;
          state_nx    = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Front-end fetch sequencer: owns the fetch PC and drives the instruction bus request/response handshake.
- Holds one fetched instruction in a single-entry output buffer for decode.
- Applies downstream stalls and branch/jump redirects; discards in-flight responses made stale by a redirect.
- Sits between the instruction bus and the decode stage, replacing a free-running PC register.

Parameters:
RESET_PC, 64'h8000_0000, fetch PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
ireq_valid  out  1  instruction bus request valid
ireq_addr  out  64  instruction bus request address
iresp_data_ok  in  1  one-cycle pulse: response for the current request
iresp_data  in  32  instruction word, valid with iresp_data_ok
redirect  in  1  jump/branch taken; flush and refetch from redirect_pc
redirect_pc  in  64  redirect target
stall  in  1  decode-side hold; buffer not consumed
stallM  in  1  memory-stage hold; buffer not consumed
if_valid  out  1  output buffer holds a valid instruction
if_pc  out  64  PC of the buffered instruction
if_instr  out  32  buffered instruction
stallI  out  1  fetch bubble; equals !if_valid
pc  out  64  current fetch PC register

Behaviour:
- Reset (asynchronous, while reset==0):
  - pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_instr=0, drain target=0.
  - ireq_valid is forced to 0 while reset==0.
  - Reset mid-transaction abandons any outstanding request; a late iresp_data_ok after release is treated as the response to the new request.
- Accept condition: accept = if_valid && !stall && !stallM.
- ireq_valid = (state != WAIT) and not in reset.
- ireq_addr = pc in REQ, and the frozen request address in DRAIN.
- Once asserted, ireq_valid and ireq_addr stay stable until iresp_data_ok.
- State REQ (buffer empty, request outstanding):
  - data_ok && !redirect: if_valid<=1, if_pc<=pc, if_instr<=iresp_data, pc<=pc+PC_STEP; go to WAIT.
  - data_ok && redirect: discard data, pc<=redirect_pc; stay in REQ (new request next cycle).
  - !data_ok && redirect: target<=redirect_pc; pc unchanged (address stays frozen); go to DRAIN.
  - Otherwise hold.
- State DRAIN (stale request outstanding):
  - ireq_valid=1 at the old address; if_valid=0.
  - redirect without data_ok: target<=redirect_pc (latest redirect wins).
  - data_ok: discard data; pc<=(redirect ? redirect_pc : target); go to REQ.
- State WAIT (buffer full, no request):
  - redirect: if_valid<=0, pc<=redirect_pc; go to REQ. Redirect has priority over stall/stallM.
  - accept without redirect: if_valid<=0; go to REQ.
  - Otherwise hold; if_* stable.
- Latency: the first request is issued on the cycle after reset release. With bus latency L (cycles from ireq_valid to data_ok), if_valid rises 1 cycle after data_ok. Unstalled throughput is one instruction per L+2 cycles.
- Arithmetic: pc+PC_STEP is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0. redirect_pc is used unaligned as given; no alignment check.
- iresp_data_ok in WAIT cannot occur (no request outstanding) and is ignored.

Test Plan:
- Reset then bus latency 2 with no stalls -> first ireq_addr=0x8000_0000; if_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; if_valid high 1 cycle per fetch; stallI=!if_valid.
- stall=1 for 5 cycles while if_valid=1 -> if_pc/if_instr stable, ireq_valid=0; one cycle after stall drops, ireq_valid=1 with ireq_addr=if_pc+4.
- Redirect to 0x8000_0100 one cycle after a request to 0x8000_0010, data_ok 3 cycles later -> ireq_addr stays 0x8000_0010 until data_ok; that data is not presented; next request is 0x8000_0100.
- Redirect coincident with data_ok (target 0x8000_0200) -> no if_valid; next-cycle ireq_addr=0x8000_0200.
- Two redirects during DRAIN (0x300 then 0x400) -> after data_ok, fetch from 0x400. Redirect in WAIT with stall=1 -> if_valid drops next cycle, fetch from target.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC, one fetch -> pc=0. Assert reset mid-DRAIN -> outputs reset immediately; after release ireq_addr=0x8000_0000.
